// File: rtl/apple1_vga_out.sv
// Registered VGA output stage for the apple1 core: expands 1-bit colours to CH_BITS
// per channel with colour/mono-phosphor modes, optional scanline dimming and a fixed pipeline.
module apple1_vga_out #(
  parameter int CH_BITS = 2,
  parameter int PIPE    = 2
) (
  input  logic               clk25,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic               scanline_en,
  input  logic               h_sync_in,
  input  logic               v_sync_in,
  input  logic               red_in,
  input  logic               grn_in,
  input  logic               blu_in,
  output logic               h_sync,
  output logic               v_sync,
  output logic [CH_BITS-1:0] red,
  output logic [CH_BITS-1:0] grn,
  output logic [CH_BITS-1:0] blu
);

  typedef enum logic [1:0] {
    MODE_COLOR = 2'b00,
    MODE_GREEN = 2'b01,
    MODE_AMBER = 2'b10,
    MODE_WHITE = 2'b11
  } mode_e;

  localparam logic [CH_BITS-1:0] F = {CH_BITS{1'b1}};

  logic  h_prev_q, v_prev_q;
  logic  par_q, par_d;
  mode_e act_mode_q, act_mode_d;
  logic  hs_fall, vs_fall, lum;

  logic [CH_BITS-1:0] red0_d, grn0_d, blu0_d;
  logic [CH_BITS-1:0] red_pipe_q [PIPE];
  logic [CH_BITS-1:0] grn_pipe_q [PIPE];
  logic [CH_BITS-1:0] blu_pipe_q [PIPE];
  logic               hs_pipe_q  [PIPE];
  logic               vs_pipe_q  [PIPE];

  assign hs_fall = h_prev_q & ~h_sync_in;
  assign vs_fall = v_prev_q & ~v_sync_in;
  assign lum     = red_in | grn_in | blu_in;

  // The mode only changes at a frame start; a frame start also restarts line parity.
  always_comb begin
    act_mode_d = act_mode_q;
    par_d      = par_q;
    if (vs_fall) begin
      act_mode_d = mode_e'(mode);
      par_d      = 1'b0;
    end else if (hs_fall) begin
      par_d = ~par_q;
    end
  end

  always_comb begin
    red0_d = '0;
    grn0_d = '0;
    blu0_d = '0;
    unique case (act_mode_q)
      MODE_COLOR: begin
        red0_d = red_in ? F : '0;
        grn0_d = grn_in ? F : '0;
        blu0_d = blu_in ? F : '0;
      end
      MODE_GREEN: grn0_d = lum ? F : '0;
      MODE_AMBER: begin
        red0_d = lum ? F : '0;
        grn0_d = lum ? (F >> 1) : '0;
      end
      MODE_WHITE: begin
        red0_d = lum ? F : '0;
        grn0_d = lum ? F : '0;
        blu0_d = lum ? F : '0;
      end
      default: ;
    endcase
    // Odd lines are dimmed to half intensity; at CH_BITS=1 that is black.
    if (scanline_en & par_q) begin
      red0_d = red0_d >> 1;
      grn0_d = grn0_d >> 1;
      blu0_d = blu0_d >> 1;
    end
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      h_prev_q   <= 1'b1;
      v_prev_q   <= 1'b1;
      par_q      <= 1'b0;
      act_mode_q <= MODE_COLOR;
      for (int i = 0; i < PIPE; i++) begin
        red_pipe_q[i] <= '0;
        grn_pipe_q[i] <= '0;
        blu_pipe_q[i] <= '0;
        hs_pipe_q[i]  <= 1'b1;
        vs_pipe_q[i]  <= 1'b1;
      end
    end else begin
      h_prev_q      <= h_sync_in;
      v_prev_q      <= v_sync_in;
      par_q         <= par_d;
      act_mode_q    <= act_mode_d;
      red_pipe_q[0] <= red0_d;
      grn_pipe_q[0] <= grn0_d;
      blu_pipe_q[0] <= blu0_d;
      hs_pipe_q[0]  <= h_sync_in;
      vs_pipe_q[0]  <= v_sync_in;
      for (int i = 1; i < PIPE; i++) begin
        red_pipe_q[i] <= red_pipe_q[i-1];
        grn_pipe_q[i] <= grn_pipe_q[i-1];
        blu_pipe_q[i] <= blu_pipe_q[i-1];
        hs_pipe_q[i]  <= hs_pipe_q[i-1];
        vs_pipe_q[i]  <= vs_pipe_q[i-1];
      end
    end
  end

  assign red    = red_pipe_q[PIPE-1];
  assign grn    = grn_pipe_q[PIPE-1];
  assign blu    = blu_pipe_q[PIPE-1];
  assign h_sync = hs_pipe_q[PIPE-1];
  assign v_sync = vs_pipe_q[PIPE-1];

endmodule

// File: tb/tb_apple1_vga_out.sv
// Directed bench for apple1_vga_out: three instances (2b/3-deep, 4b/2-deep, 1b/1-deep)
// share one stimulus stream and are checked against hand-computed values.
module tb_apple1_vga_out;

  logic       clk25 = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic       scanline_en;
  logic       h_sync_in, v_sync_in;
  logic       red_in, grn_in, blu_in;

  logic       hsA, vsA, hsB, vsB, hsC, vsC;
  logic [1:0] redA, grnA, bluA;
  logic [3:0] redB, grnB, bluB;
  logic [0:0] redC, grnC, bluC;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk25 = ~clk25;

  apple1_vga_out #(.CH_BITS(2), .PIPE(3)) dutA (
    .clk25(clk25), .rst(rst), .mode(mode), .scanline_en(scanline_en),
    .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .red_in(red_in), .grn_in(grn_in), .blu_in(blu_in),
    .h_sync(hsA), .v_sync(vsA), .red(redA), .grn(grnA), .blu(bluA));

  apple1_vga_out #(.CH_BITS(4), .PIPE(2)) dutB (
    .clk25(clk25), .rst(rst), .mode(mode), .scanline_en(scanline_en),
    .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .red_in(red_in), .grn_in(grn_in), .blu_in(blu_in),
    .h_sync(hsB), .v_sync(vsB), .red(redB), .grn(grnB), .blu(bluB));

  apple1_vga_out #(.CH_BITS(1), .PIPE(1)) dutC (
    .clk25(clk25), .rst(rst), .mode(mode), .scanline_en(scanline_en),
    .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .red_in(red_in), .grn_in(grn_in), .blu_in(blu_in),
    .h_sync(hsC), .v_sync(vsC), .red(redC), .grn(grnC), .blu(bluC));

  // Advance n rising edges and land 1 ns after the last one, where outputs are stable.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk25);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic g, input logic b,
                               input logic hs, input logic vs);
    red_in    = r;
    grn_in    = g;
    blu_in    = b;
    h_sync_in = hs;
    v_sync_in = vs;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkB(input string tag, input logic [3:0] r, input logic [3:0] g,
                        input logic [3:0] b);
    checkOutput({tag, "_redB"}, {4'h0, redB}, {4'h0, r});
    checkOutput({tag, "_grnB"}, {4'h0, grnB}, {4'h0, g});
    checkOutput({tag, "_bluB"}, {4'h0, bluB}, {4'h0, b});
  endtask

  initial begin
    rst         = 1'b1;
    mode        = 2'b00;
    scanline_en = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    // Reset held for three edges with lit pixels and low syncs on the inputs.
    tick(1);
    checkOutput("rst_redA", {6'h0, redA}, 8'h00);
    checkOutput("rst_hsA", {7'h0, hsA}, 8'h01);
    checkOutput("rst_vsC", {7'h0, vsC}, 8'h01);
    tick(2);
    checkB("rst", 4'h0, 4'h0, 4'h0);
    rst = 1'b0;
    tick(2);
    checkOutput("rel_redA", {6'h0, redA}, 8'h00);
    checkOutput("rel_hsA", {7'h0, hsA}, 8'h01);
    tick(1);
    checkOutput("rel_redA_F", {6'h0, redA}, 8'h03);
    checkOutput("rel_bluA_F", {6'h0, bluA}, 8'h03);
    checkOutput("rel_hsA_lo", {7'h0, hsA}, 8'h00);
    checkOutput("rel_vsA_lo", {7'h0, vsA}, 8'h00);
    checkB("rel", 4'hF, 4'hF, 4'hF);

    // Latency/alignment: red and hsync toggle together, appear 3 edges later on A.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(4);
    checkOutput("lat_pre_redA", {6'h0, redA}, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(2);
    checkOutput("lat2_redA", {6'h0, redA}, 8'h00);
    checkOutput("lat2_hsA", {7'h0, hsA}, 8'h01);
    tick(1);
    checkOutput("lat3_redA", {6'h0, redA}, 8'h03);
    checkOutput("lat3_hsA", {7'h0, hsA}, 8'h00);

    // Mode request mid-frame is ignored until the next vsync fall.
    mode = 2'b10;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(4);
    checkOutput("gate_redA", {6'h0, redA}, 8'h03);
    checkOutput("gate_grnA", {6'h0, grnA}, 8'h03);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(4);
    checkOutput("amber_redA", {6'h0, redA}, 8'h03);
    checkOutput("amber_grnA", {6'h0, grnA}, 8'h01);
    checkOutput("amber_bluA", {6'h0, bluA}, 8'h00);
    checkB("amber", 4'hF, 4'h7, 4'h0);
    checkOutput("amber_redC", {7'h0, redC}, 8'h01);
    checkOutput("amber_grnC", {7'h0, grnC}, 8'h00);

    // White mono with scanlines; lum driven by blue only.
    mode        = 2'b11;
    scanline_en = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick(4);
    checkB("line0", 4'hF, 4'hF, 4'hF);
    for (int line = 1; line <= 3; line++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      tick(1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      tick(4);
      if (line == 2) checkB("line2", 4'hF, 4'hF, 4'hF);
      else           checkB("line_odd", 4'h7, 4'h7, 4'h7);
    end
    checkOutput("dim_redA", {6'h0, redA}, 8'h01);
    checkOutput("dim_bluC", {7'h0, bluC}, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick(4);
    checkB("vs_clear", 4'hF, 4'hF, 4'hF);

    // Simultaneous h/v falls with parity set: clearing wins.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick(4);
    checkB("sim_pre", 4'h7, 4'h7, 4'h7);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick(4);
    checkB("sim_post", 4'hF, 4'hF, 4'hF);

    // Amber on a dimmed line, including the 1-bit width corner.
    mode = 2'b10;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(4);
    checkOutput("adim_redC", {7'h0, redC}, 8'h00);
    checkOutput("adim_grnC", {7'h0, grnC}, 8'h00);
    checkB("adim", 4'h7, 4'h3, 4'h0);
    checkOutput("adim_redA", {6'h0, redA}, 8'h01);
    checkOutput("adim_grnA", {6'h0, grnA}, 8'h00);

    // Mid-frame reset clears the pipeline immediately.
    rst = 1'b1;
    tick(1);
    checkOutput("mrst_redA", {6'h0, redA}, 8'h00);
    checkB("mrst", 4'h0, 4'h0, 4'h0);
    rst = 1'b0;
    tick(4);
    checkOutput("mrst_color_redB", {4'h0, redB}, 8'h0F);
    checkOutput("mrst_color_grnB", {4'h0, grnB}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
